// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: state encoding, default timing,
// HD44780 command bytes and the per-requester byte extractor.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_PWR,
      S_IDLE,
      S_SETUP,
      S_EHIGH,
      S_SETTLE
   } lcd_state_t;

   localparam int CNT_W   = 21;
   localparam int IDX_W   = 2;
   localparam int MAX_REQ = 4;

   localparam int DEF_POWER_ON_CYCLES = 2_000_000;
   localparam int DEF_SETUP_CYCLES    = 5_000;
   localparam int DEF_E_HIGH_CYCLES   = 10_000;
   localparam int DEF_SETTLE_SHORT    = 5_000;
   localparam int DEF_SETTLE_LONG     = 100_000;
   localparam int DEF_LOCK_TIMEOUT    = 1_000_000;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   function automatic logic [7:0] req_byte(input logic [8*MAX_REQ-1:0] bus,
                                           input logic [IDX_W-1:0]     i);
      return bus[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_bus_arbiter_select.sv
// Winner selection among pending LCD requesters; the lock owner overrides the policy.
// LCD_ARB_RR_EN selects round-robin, otherwise fixed priority (lowest index wins).
module lcd_req_select
   import lcd_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]  valid,
   input  logic             lock_en,
   input  logic [IDX_W-1:0] lock_owner,
`ifdef LCD_ARB_RR_EN
   input  logic [IDX_W-1:0] rr_ptr,
`endif
   output logic [NREQ-1:0]  win_onehot,
   output logic [IDX_W-1:0] win_idx
);

`ifdef LCD_ARB_RR_EN
   int idx;
`endif

   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
`ifdef LCD_ARB_RR_EN
      idx        = 0;
`endif
      if (lock_en) begin
         if (valid[lock_owner]) begin
            win_onehot[lock_owner] = 1'b1;
            win_idx                = lock_owner;
         end
      end else begin
`ifdef LCD_ARB_RR_EN
         // Walk from farthest to nearest so the slot right after rr_ptr is kept last.
         for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + 1 + k) % NREQ;
            if (valid[idx]) begin
               win_onehot      = '0;
               win_onehot[idx] = 1'b1;
               win_idx         = IDX_W'(idx);
            end
         end
`else
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
               win_onehot    = '0;
               win_onehot[i] = 1'b1;
               win_idx       = IDX_W'(i);
            end
         end
`endif
      end
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 bus among NREQ writers: power-on delay, E strobe timing, line lock.
// Build option LCD_ARB_RR_EN: round-robin arbitration instead of fixed priority.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ            = 3,
   parameter int POWER_ON_CYCLES = DEF_POWER_ON_CYCLES,
   parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
   parameter int E_HIGH_CYCLES   = DEF_E_HIGH_CYCLES,
   parameter int SETTLE_SHORT    = DEF_SETTLE_SHORT,
   parameter int SETTLE_LONG     = DEF_SETTLE_LONG,
   parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_rs,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_long,
   input  logic [NREQ-1:0]   req_lock,
   output logic [NREQ-1:0]   req_ready,
   output logic [IDX_W-1:0]  grant_id,
   output logic              busy,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic              lcd_e,
   output logic [7:0]        lcd_data
);

   localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(POWER_ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] EHIGH_LAST  = CNT_W'(E_HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SETTLE_SHORT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(SETTLE_LONG - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

   lcd_state_t           state;
   logic [CNT_W-1:0]     cnt;
   logic                 long_sel;
   logic                 lock_en;
   logic [IDX_W-1:0]     lock_owner;
   logic [NREQ-1:0]      win_onehot;
   logic [IDX_W-1:0]     win_idx;
   logic                 accept;
   logic [8*MAX_REQ-1:0] data_pad;
`ifdef LCD_ARB_RR_EN
   logic [IDX_W-1:0]     rr_ptr;
`endif

   assign data_pad  = (8*MAX_REQ)'(req_data);
   assign req_ready = (state == S_IDLE) ? win_onehot : '0;
   assign accept    = (state == S_IDLE) && (|win_onehot);
   assign lcd_rw    = 1'b0;

   lcd_req_select #(.NREQ(NREQ)) u_select (
      .valid      (req_valid),
      .lock_en    (lock_en),
      .lock_owner (lock_owner),
`ifdef LCD_ARB_RR_EN
      .rr_ptr     (rr_ptr),
`endif
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_PWR;
         cnt        <= '0;
         busy       <= 1'b1;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         long_sel   <= 1'b0;
         grant_id   <= '0;
         lock_en    <= 1'b0;
         lock_owner <= '0;
`ifdef LCD_ARB_RR_EN
         rr_ptr     <= IDX_W'(NREQ - 1);
`endif
      end else begin
         case (state)
            S_PWR: begin
               if (cnt == PWR_LAST) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (accept) begin
                  state      <= S_SETUP;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  lcd_rs     <= req_rs[win_idx];
                  lcd_data   <= req_byte(data_pad, win_idx);
                  long_sel   <= req_long[win_idx];
                  grant_id   <= win_idx;
                  lock_en    <= req_lock[win_idx];
                  lock_owner <= win_idx;
`ifdef LCD_ARB_RR_EN
                  rr_ptr     <= win_idx;
`endif
               end else if (lock_en) begin
                  // An idle cycle under lock means the owner is not offering anything.
                  if (cnt == LOCK_LAST) begin
                     lock_en <= 1'b0;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= S_EHIGH;
                  cnt   <= '0;
                  lcd_e <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_EHIGH: begin
               if (cnt == EHIGH_LAST) begin
                  state <= S_SETTLE;
                  cnt   <= '0;
                  lcd_e <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               if (cnt == (long_sel ? LONG_LAST : SHORT_LAST)) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_PWR;
               cnt   <= '0;
               busy  <= 1'b1;
               lcd_e <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomised and directed bench for lcd_bus_arbiter against a transaction-timestamp model.
// Honours LCD_ARB_RR_EN in its arbitration model.
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   localparam int NREQ = 3;
   localparam int PWR  = 20;
   localparam int SU   = 2;
   localparam int EH   = 3;
   localparam int SS   = 4;
   localparam int SL   = 10;
   localparam int LT   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_rs, req_long, req_lock;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [1:0]        grant_id;
   logic              busy, lcd_rs, lcd_rw, lcd_e;
   logic [7:0]        lcd_data;

   always #5 clk = ~clk;

   lcd_bus_arbiter #(
      .NREQ(NREQ), .POWER_ON_CYCLES(PWR), .SETUP_CYCLES(SU), .E_HIGH_CYCLES(EH),
      .SETTLE_SHORT(SS), .SETTLE_LONG(SL), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
      .req_long(req_long), .req_lock(req_lock), .req_ready(req_ready), .grant_id(grant_id),
      .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: the bus is free from free_at on; the strobe and held
   // outputs follow from the timestamp and fields of the last accept.
   int         cyc, free_at, last_t, rr_last, last_id, lock_owner_m;
   bit         has_acc, lock_en_m;
   logic       last_rs;
   logic [7:0] last_data;
   int         dut_win, dut_t, dut_acc0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_reset();
      cyc = 0; free_at = PWR; last_t = -100; rr_last = NREQ - 1; last_id = 0;
      lock_owner_m = 0; has_acc = 0; lock_en_m = 0; last_rs = 0; last_data = 8'h00;
   endtask

   function automatic logic [NREQ-1:0] exp_ready_f();
      logic [NREQ-1:0] r;
      int idx;
      r = '0;
      if (cyc < free_at) return r;
      if (lock_en_m && (cyc - free_at) < LT) begin
         if (req_valid[lock_owner_m]) r[lock_owner_m] = 1'b1;
         return r;
      end
`ifdef LCD_ARB_RR_EN
      for (int k = 0; k < NREQ; k++) begin
         idx = (rr_last + 1 + k) % NREQ;
         if (req_valid[idx]) begin r[idx] = 1'b1; return r; end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         idx = i;
         if (req_valid[idx]) begin r[idx] = 1'b1; return r; end
      end
`endif
      return r;
   endfunction

   task automatic step();
      logic [NREQ-1:0] er, vr;
      bit e_exp;
      int a;
      @(negedge clk);
      er = exp_ready_f();
      e_exp = has_acc && (cyc >= last_t + 1 + SU) && (cyc < last_t + 1 + SU + EH);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(cyc < free_at));
      chk("lcd_e", 32'(lcd_e), 32'(e_exp));
      chk("lcd_rs", 32'(lcd_rs), 32'(last_rs));
      chk("lcd_data", 32'(lcd_data), 32'(last_data));
      chk("grant_id", 32'(grant_id), 32'(last_id));
      chk("lcd_rw", 32'(lcd_rw), 32'(0));
      vr = req_valid & req_ready;
      dut_win = -1;
      dut_t = cyc;
      for (int i = NREQ - 1; i >= 0; i--) if (vr[i]) dut_win = i;
      if (dut_win == 0) dut_acc0++;
      if (er != '0) begin
         a = 0;
         for (int i = 0; i < NREQ; i++) if (er[i]) a = i;
         last_t = cyc; has_acc = 1; last_rs = req_rs[a]; last_data = req_data[8*a +: 8];
         last_id = a; lock_en_m = req_lock[a]; lock_owner_m = a; rr_last = a;
         free_at = cyc + 1 + SU + EH + (req_long[a] ? SL : SS);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until(input int who, input int limit, output int t, output int w);
      bit seen;
      seen = 0; t = -1; w = -1;
      for (int k = 0; k < limit && !seen; k++) begin
         step();
         if (dut_win >= 0 && (who < 0 || dut_win == who)) begin
            seen = 1; t = dut_t; w = dut_win;
         end
      end
      chk("accept_seen", 32'(seen), 32'(1));
   endtask

   task automatic offer(input int i, input logic rs, input logic [7:0] d,
                        input logic lng, input logic lk);
      req_valid[i] = 1'b1; req_rs[i] = rs; req_data[8*i +: 8] = d;
      req_long[i] = lng; req_lock[i] = lk;
   endtask

   task automatic drop(input int i);
      req_valid[i] = 1'b0;
   endtask

   initial begin
      int t, t2, t3, w, wprev, base0;
      rst = 1'b1;
      req_valid = '0; req_rs = '0; req_long = '0; req_lock = '0; req_data = '0;
      dut_acc0 = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(1));
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_lcd_e", 32'(lcd_e), 32'(0));
      chk("rst_lcd_data", 32'(lcd_data), 32'(0));
      chk("rst_grant", 32'(grant_id), 32'(0));
      chk("rst_lcd_rs", 32'(lcd_rs), 32'(0));

      // Power-on delay, then short and long settle spacing.
      offer(0, 1'b0, 8'h38, 1'b0, 1'b0);
      rst = 1'b0;
      run_until(0, 100, t, w);
      chk("first_accept_cycle", 32'(t), 32'(PWR));
      offer(0, 1'b0, CMD_CLEAR, 1'b1, 1'b0);
      run_until(0, 100, t2, w);
      chk("short_cycle_gap", 32'(t2 - t), 32'(1 + SU + EH + SS));
      offer(0, 1'b1, 8'h48, 1'b0, 1'b0);
      run_until(0, 100, t3, w);
      chk("long_settle_gap", 32'(t3 - t2), 32'(1 + SU + EH + SL));

      // Contention between req0 and req1.
      offer(0, 1'b1, 8'h50, 1'b0, 1'b0);
      offer(1, 1'b1, 8'h51, 1'b0, 1'b0);
      wprev = -1;
      for (int n = 0; n < 6; n++) begin
         run_until(-1, 100, t, w);
`ifdef LCD_ARB_RR_EN
         if (n > 0) chk("rr_alternate", 32'(w), 32'(1 - wprev));
`else
         chk("fixed_prio_winner", 32'(w), 32'(0));
`endif
         wprev = w;
         if (w >= 0) offer(w, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      end
      drop(0); drop(1);

      // Locked line write by req1 with req0 pending throughout.
      offer(1, 1'b0, CMD_LINE2, 1'b0, 1'b1);
      run_until(1, 100, t, w);
      offer(0, 1'b1, 8'h5A, 1'b0, 1'b0);
      base0 = dut_acc0;
      for (int c = 1; c <= 16; c++) begin
         offer(1, 1'b1, 8'(8'h30 + c), 1'b0, c < 16);
         run_until(1, 100, t, w);
      end
      drop(1);
      chk("lock_req0_grants", 32'(dut_acc0 - base0), 32'(0));
      run_until(-1, 100, t, w);
      chk("unlock_winner", 32'(w), 32'(0));
      drop(0);

      // Lock timeout: owner req2 goes quiet, req0 waits for the drop.
      offer(2, 1'b0, CMD_LINE1, 1'b0, 1'b1);
      run_until(2, 100, t, w);
      drop(2);
      offer(0, 1'b1, 8'h42, 1'b0, 1'b0);
      run_until(0, 100, t2, w);
      chk("lock_timeout_gap", 32'(t2 - t), 32'(1 + SU + EH + SS + LT));
      drop(0);

      // Random traffic, including withdrawals and abandoned locks.
      for (int n = 0; n < 600; n++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (dut_win == i) drop(i);
            else if (!req_valid[i] && $urandom_range(0, 99) < 25)
               offer(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            else if (req_valid[i] && $urandom_range(0, 99) < 3) drop(i);
         end
      end
      req_valid = '0;

      // Reset in the middle of an E pulse.
      offer(2, 1'b1, 8'h41, 1'b0, 1'b1);
      run_until(2, 200, t, w);
      drop(2);
      for (int k = 0; k < 20 && !lcd_e; k++) step();
      chk("pulse_seen", 32'(lcd_e), 32'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_lcd_e", 32'(lcd_e), 32'(0));
      chk("midrst_lcd_data", 32'(lcd_data), 32'(0));
      chk("midrst_lcd_rs", 32'(lcd_rs), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(1));
      chk("midrst_grant", 32'(grant_id), 32'(0));
      offer(0, 1'b0, 8'h38, 1'b0, 1'b0);
      chk("midrst_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      run_until(0, 100, t, w);
      chk("ready_after_reset", 32'(t), 32'(PWR));
      drop(0);
      repeat (12) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
